// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: forwarding selects and shadow-stage bundles.
// Used by hazard_fwd_unit and fwd_select.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] dest;
    logic       regwrite;
    logic       memread;
  } ex_sh_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       regwrite;
  } wr_sh_t;

  function automatic logic writes(
    input logic       valid,
    input logic       regwrite,
    input logic [4:0] dest,
    input logic [4:0] r
  );
    return valid & regwrite &
           (dest == r) & (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Per-operand forwarding select: MEM result beats WB result beats regfile.
// Register 0 never matches.
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       mem_valid,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_dest,
  input  logic       wb_valid,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_dest,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    if (writes(mem_valid, mem_regwrite,
               mem_dest, src))
      sel = FWD_MEM;
    else if (writes(wb_valid, wb_regwrite,
                    wb_dest, src))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control with EX/MEM/WB shadow stages.
// HAZARD_FWD_EN enables forwarding; otherwise RAW hazards stall instead.
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_branch_taken,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  ex_sh_t ex, ex_d;
  wr_sh_t mem, wb;
  logic   hit_ex, hit_mem, raw_stall;

  assign hit_ex =
    (id_uses_rs &
     writes(ex.valid, ex.regwrite, ex.dest, id_rs)) |
    (id_uses_rt &
     writes(ex.valid, ex.regwrite, ex.dest, id_rt));

  assign hit_mem =
    (id_uses_rs &
     writes(mem.valid, mem.regwrite, mem.dest, id_rs)) |
    (id_uses_rt &
     writes(mem.valid, mem.regwrite, mem.dest, id_rt));

`ifdef HAZARD_FWD_EN
  logic [4:0] src_a, src_b;

  assign raw_stall = id_valid & ex.memread & hit_ex;
  assign src_a = ex.uses_rs ? ex.rs : REG_ZERO;
  assign src_b = ex.uses_rt ? ex.rt : REG_ZERO;

  fwd_select u_fwd_a (
    .src          (src_a),
    .mem_valid    (mem.valid),
    .mem_regwrite (mem.regwrite),
    .mem_dest     (mem.dest),
    .wb_valid     (wb.valid),
    .wb_regwrite  (wb.regwrite),
    .wb_dest      (wb.dest),
    .sel          (fwd_a_sel)
  );

  fwd_select u_fwd_b (
    .src          (src_b),
    .mem_valid    (mem.valid),
    .mem_regwrite (mem.regwrite),
    .mem_dest     (mem.dest),
    .wb_valid     (wb.valid),
    .wb_regwrite  (wb.regwrite),
    .wb_dest      (wb.dest),
    .sel          (fwd_b_sel)
  );
`else
  logic unused_shadow;

  // Without bypass paths any in-flight EX/MEM writer must drain first.
  assign raw_stall = id_valid & (hit_ex | hit_mem);
  assign fwd_a_sel = FWD_REG;
  assign fwd_b_sel = FWD_REG;
  assign unused_shadow = ^{ex.rs, ex.rt, ex.uses_rs,
                           ex.uses_rt, ex.memread, wb};
`endif

  assign flush = rst_n & ex_branch_taken;
  assign stall = raw_stall & ~ex_branch_taken;

  always_comb begin
    ex_d = '0;
    if (!(stall | flush)) begin
      ex_d.valid    = id_valid;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.uses_rs  = id_uses_rs;
      ex_d.uses_rt  = id_uses_rt;
      ex_d.dest     = id_dest;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      ex  <= ex_d;
      mem <= '{valid:    ex.valid,
               dest:     ex.dest,
               regwrite: ex.regwrite};
      wb  <= mem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit; expectations follow HAZARD_FWD_EN.
// Uses a narrow stall counter so saturation is reachable quickly.
module tb_hazard_fwd_unit;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [4:0]    id_rs, id_rt, id_dest;
  logic          id_uses_rs, id_uses_rt;
  logic          id_regwrite, id_memread;
  logic          ex_branch_taken;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall, flush;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_W(5), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_dest         (id_dest),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall           (stall),
    .flush           (flush),
    .stall_cnt       (stall_cnt)
  );

  typedef struct {
    bit       v;
    bit [4:0] rs, rt;
    bit       urs, urt;
    bit [4:0] d;
    bit       rw, mr;
  } ins_t;

  typedef struct {
    bit [1:0]    a, b;
    bit          st, fl;
    bit [CW-1:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  ins_t        h[3];
  bit [CW-1:0] cnt_m;
  int          n_run = 0;
  int          n_fail = 0;
  bit          fwd_on;
  bit          st;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic ins_t mk(bit v,
      bit [4:0] rs, bit [4:0] rt, bit urs, bit urt,
      bit [4:0] d, bit rw, bit mr);
    ins_t i;
    i.v = v; i.rs = rs; i.rt = rt;
    i.urs = urs; i.urt = urt;
    i.d = d; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic bit wr(ins_t i, bit [4:0] r);
    return i.v && i.rw && i.d == r && r != 0;
  endfunction

  function automatic bit [1:0] fsel(bit u, bit [4:0] r);
    if (!fwd_on || !u) return 2'b00;
    if (wr(h[1], r)) return 2'b10;
    if (wr(h[2], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit reads(ins_t p, ins_t c);
    return (c.urs && wr(p, c.rs)) ||
           (c.urt && wr(p, c.rt));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      h[i] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    cnt_m = '0;
  endtask

  task automatic drive(ins_t id, bit br);
    id_valid        = id.v;
    id_rs           = id.rs;
    id_rt           = id.rt;
    id_uses_rs      = id.urs;
    id_uses_rt      = id.urt;
    id_dest         = id.d;
    id_regwrite     = id.rw;
    id_memread      = id.mr;
    ex_branch_taken = br;
  endtask

  // Called just after a rising edge; one ID slot per call.
  task automatic cyc(ins_t id, bit br, output bit s);
    exp_t e;
    bit   h0, h1;
    drive(id, br);
    h0 = reads(h[0], id);
    h1 = reads(h[1], id);
    if (fwd_on) s = id.v && !br && h[0].mr && h0;
    else        s = id.v && !br && (h0 || h1);
    e.a   = fsel(h[0].urs, h[0].rs);
    e.b   = fsel(h[0].urt, h[0].rt);
    e.st  = s;
    e.fl  = br;
    e.cnt = cnt_m;
    sbq.push_back(e);
    h[2] = h[1];
    h[1] = h[0];
    h[0] = (s || br) ? mk(0, 0, 0, 0, 0, 0, 0, 0) : id;
    if (s && cnt_m != '1) cnt_m++;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("fwd_a", 32'(fwd_a_sel), 32'(e.a));
      check("fwd_b", 32'(fwd_b_sel), 32'(e.b));
      check("stall", 32'(stall), 32'(e.st));
      check("flush", 32'(flush), 32'(e.fl));
      check("cnt", 32'(stall_cnt), 32'(e.cnt));
    end
  end

  task automatic check_reset(string tag);
    check({tag, "_fa"}, 32'(fwd_a_sel), 0);
    check({tag, "_fb"}, 32'(fwd_b_sel), 0);
    check({tag, "_st"}, 32'(stall), 0);
    check({tag, "_fl"}, 32'(flush), 0);
    check({tag, "_cnt"}, 32'(stall_cnt), 0);
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++)
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, st);
  endtask

  task automatic hold(ins_t id);
    for (int i = 0; i < 4; i++) begin
      cyc(id, 0, st);
      if (!st) break;
    end
  endtask

  ins_t add3, sub4, or6, lw8, add10, add0, use0;

  initial begin
`ifdef HAZARD_FWD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif
    add3  = mk(1, 1, 2, 1, 1, 3, 1, 0);
    sub4  = mk(1, 3, 5, 1, 1, 4, 1, 0);
    or6   = mk(1, 7, 3, 1, 1, 6, 1, 0);
    lw8   = mk(1, 9, 0, 1, 0, 8, 1, 1);
    add10 = mk(1, 8, 8, 1, 1, 10, 1, 0);
    add0  = mk(1, 1, 2, 1, 1, 0, 1, 0);
    use0  = mk(1, 0, 0, 1, 1, 4, 1, 0);

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 0);
    model_reset();
    #12;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // distance 1 ALU
    cyc(add3, 0, st);
    hold(sub4);
    nops(3);
    // distance 2
    cyc(add3, 0, st);
    nops(1);
    hold(or6);
    nops(3);
    // MEM and WB both write $3
    cyc(add3, 0, st);
    hold(add3);
    hold(or6);
    nops(3);
    // load-use
    cyc(lw8, 0, st);
    hold(add10);
    nops(3);
    // register zero
    cyc(add0, 0, st);
    hold(use0);
    cyc(mk(1, 9, 0, 1, 0, 0, 1, 1), 0, st);
    hold(use0);
    nops(3);
    // load-use while branch taken
    cyc(lw8, 0, st);
    cyc(add10, 1, st);
    hold(add10);
    nops(3);

    // saturate the stall counter
    for (int i = 0; i < 300; i++) begin
      cyc(lw8, 0, st);
      cyc(add10, 0, st);
      cyc(add10, 0, st);
    end
    check("cnt_sat", 32'(stall_cnt), 32'hFF);

    // reset in the middle of a stall
    cyc(lw8, 0, st);
    drive(add10, 0);
    #1;
    check("stall_pre", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    check_reset("amid");
    @(posedge clk); #1;
    check_reset("hold");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    cyc(add3, 0, st);
    hold(sub4);
    nops(2);

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
